// File: rtl/ean13_pkg.sv
// rtl/ean13_pkg.sv - shared constants, FSM state type and digit weighting for the EAN-13 confirmer
package ean13_pkg;

  localparam int EAN13_DIGITS = 13;
  localparam int CODE_W       = 52;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_COMPARE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  // Digit 0 is leftmost; odd positions carry weight 3, even positions weight 1.
  function automatic logic [1:0] digit_weight(input logic [3:0] idx);
    return idx[0] ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/ean13_checksum.sv
// rtl/ean13_checksum.sv - serial EAN-13 weighted checksum and BCD check, one digit per cycle
module ean13_checksum
  import ean13_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  output logic              done,
  output logic              valid
);

  logic       run;
  logic [3:0] idx;
  logic [7:0] sum;
  logic       bad;
  logic [5:0] bit_pos;
  logic [3:0] digit;
  logic [7:0] sum_next;
  logic       bad_next;

  // Select the current digit and fold it into the running sum and BCD flag.
  always_comb begin
    bit_pos  = 6'd48 - {idx, 2'b00};
    digit    = code[bit_pos +: 4];
    sum_next = sum + ({4'd0, digit} * {6'd0, digit_weight(idx)});
    bad_next = bad | (digit > 4'd9);
  end

  // The last digit is folded in combinationally so the verdict is ready in the 13th cycle.
  assign done  = run && (idx == 4'(EAN13_DIGITS - 1));
  assign valid = !bad_next && ((sum_next % 8'd10) == 8'd0);

  // Step through digits 0..12; code is held stable by the caller while running.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run <= 1'b0;
      idx <= 4'd0;
      sum <= 8'd0;
      bad <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      idx <= 4'd0;
      sum <= 8'd0;
      bad <= 1'b0;
    end else if (run) begin
      sum <= sum_next;
      bad <= bad_next;
      if (done) run <= 1'b0;
      else      idx <= idx + 4'd1;
    end
  end

endmodule

// File: rtl/ean13_scan_ctrl.sv
// rtl/ean13_scan_ctrl.sv - scan-line gating plus checksum, per-frame voting and hold-off of EAN-13 reads
module ean13_scan_ctrl
  import ean13_pkg::*;
#(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int SCAN_FIRST    = 16,
  parameter int SCAN_STEP     = 8,
  parameter int SCAN_LAST     = 464,
  parameter int CONFIRM_COUNT = 3,
  parameter int HOLD_FRAMES   = 30
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iPixelSync,
  input  logic              iPixelActive,
  input  logic              iScanNewData,
  input  logic [CODE_W-1:0] iScanCode,
  output logic              oScanEnable,
  output logic [CODE_W-1:0] oCode,
  output logic              oCodeValid,
  input  logic              iCodeReady,
  output logic              oChecksumErr,
  output logic              oOverrun,
  output logic              oBusy
);

  if (H_ACTIVE < 1 || SCAN_STEP < 1 || SCAN_FIRST > SCAN_LAST || SCAN_LAST >= V_ACTIVE ||
      CONFIRM_COUNT < 1 || CONFIRM_COUNT > 15 || HOLD_FRAMES < 0 || HOLD_FRAMES > 255) begin : g_bad_params
    $error("ean13_scan_ctrl: parameter set out of range");
  end

  localparam logic [15:0] FIRST   = 16'(SCAN_FIRST);
  localparam logic [15:0] STEP    = 16'(SCAN_STEP);
  localparam logic [15:0] LAST    = 16'(SCAN_LAST);
  localparam logic [3:0]  CONFIRM = 4'(CONFIRM_COUNT);
  localparam logic [7:0]  HOLD    = 8'(HOLD_FRAMES);

  logic        frame_valid;
  logic        active_d;
  logic [15:0] line_cnt;
  logic [15:0] next_sel;
  logic [15:0] line_next;
  logic        line_fall;

  state_t            state;
  logic [CODE_W-1:0] cur_code;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] last_code;
  logic [3:0]        count;
  logic [7:0]        hold;
  logic              chk_ok;
  logic              cs_done;
  logic              cs_valid;

  logic [CODE_W-1:0] cmp_cand;
  logic [3:0]        cmp_cnt;
  logic [3:0]        new_cnt;
  logic [7:0]        hold_eff;
  logic              suppress;
  logic              report;

  assign line_fall = active_d & ~iPixelActive;
  assign line_next = line_cnt + 16'd1;
  assign oBusy     = (state != S_IDLE);

  // Track the line index and decide, one line ahead, whether the scanner sees it.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      frame_valid <= 1'b0;
      active_d    <= 1'b0;
      line_cnt    <= 16'd0;
      next_sel    <= 16'd0;
      oScanEnable <= 1'b0;
    end else begin
      active_d <= iPixelActive;
      if (iPixelSync) begin
        frame_valid <= 1'b1;
        line_cnt    <= 16'd0;
        if (FIRST == 16'd0) begin
          oScanEnable <= 1'b1;
          next_sel    <= STEP;
        end else begin
          oScanEnable <= 1'b0;
          next_sel    <= FIRST;
        end
      end else if (line_fall) begin
        line_cnt <= line_next;
        if (frame_valid && line_next == next_sel && line_next <= LAST) begin
          oScanEnable <= 1'b1;
          next_sel    <= next_sel + STEP;
        end else begin
          oScanEnable <= 1'b0;
        end
      end
    end
  end

  ean13_checksum u_checksum (
    .clk    (iClk),
    .resetn (iRstN),
    .start  ((state == S_IDLE) && iScanNewData),
    .code   (cur_code),
    .done   (cs_done),
    .valid  (cs_valid)
  );

  // Vote against the candidate as it will look after a coincident frame start.
  always_comb begin
    cmp_cand = iPixelSync ? '0 : cand;
    cmp_cnt  = iPixelSync ? 4'd0 : count;
    hold_eff = (iPixelSync && hold != 8'd0) ? hold - 8'd1 : hold;
    if (cur_code == cmp_cand) new_cnt = (cmp_cnt == 4'd15) ? 4'd15 : cmp_cnt + 4'd1;
    else                      new_cnt = 4'd1;
    suppress = (cur_code == last_code) && (hold_eff != 8'd0);
    report   = (new_cnt >= CONFIRM) && !suppress;
  end

  // Read acceptance, checksum wait, vote and downstream handshake.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state        <= S_IDLE;
      cur_code     <= '0;
      cand         <= '0;
      last_code    <= '0;
      count        <= 4'd0;
      hold         <= 8'd0;
      chk_ok       <= 1'b0;
      oCode        <= '0;
      oCodeValid   <= 1'b0;
      oChecksumErr <= 1'b0;
      oOverrun     <= 1'b0;
    end else begin
      oChecksumErr <= 1'b0;
      oOverrun     <= 1'b0;
      if (iPixelSync) begin
        cand  <= '0;
        count <= 4'd0;
        if (hold != 8'd0) hold <= hold - 8'd1;
      end
      case (state)
        S_IDLE: begin
          if (iScanNewData) begin
            cur_code <= iScanCode;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (iScanNewData) oOverrun <= 1'b1;
          if (cs_done) begin
            chk_ok       <= cs_valid;
            oChecksumErr <= !cs_valid;
            state        <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (iScanNewData) oOverrun <= 1'b1;
          if (!chk_ok) begin
            state <= S_IDLE;
          end else begin
            cand  <= cur_code;
            count <= new_cnt;
            if (report) begin
              oCode      <= cur_code;
              oCodeValid <= 1'b1;
              state      <= S_OUTPUT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_OUTPUT: begin
          if (iScanNewData) oOverrun <= 1'b1;
          if (iCodeReady) begin
            last_code  <= oCode;
            hold       <= HOLD;
            count      <= 4'd0;
            oCodeValid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ean13_scan_ctrl.sv
// tb/tb_ean13_scan_ctrl.sv - directed scoreboard bench for ean13_scan_ctrl
module tb_ean13_scan_ctrl;

  localparam logic [51:0] CODE_A     = 52'h4006381333931;
  localparam logic [51:0] CODE_B     = 52'h5901234123457;
  localparam logic [51:0] CODE_A_BAD = 52'h4006381333932;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iPixelSync = 1'b0;
  logic        iPixelActive = 1'b0;
  logic        iScanNewData = 1'b0;
  logic [51:0] iScanCode = '0;
  logic        iCodeReady = 1'b0;
  logic        oScanEnable;
  logic [51:0] oCode;
  logic        oCodeValid;
  logic        oChecksumErr;
  logic        oOverrun;
  logic        oBusy;

  int          total = 0;
  int          passed = 0;
  logic [51:0] exp_q[$];

  ean13_scan_ctrl #(
    .H_ACTIVE      (4),
    .V_ACTIVE      (12),
    .SCAN_FIRST    (2),
    .SCAN_STEP     (3),
    .SCAN_LAST     (8),
    .CONFIRM_COUNT (3),
    .HOLD_FRAMES   (2)
  ) dut (
    .iClk         (iClk),
    .iRstN        (iRstN),
    .iPixelSync   (iPixelSync),
    .iPixelActive (iPixelActive),
    .iScanNewData (iScanNewData),
    .iScanCode    (iScanCode),
    .oScanEnable  (oScanEnable),
    .oCode        (oCode),
    .oCodeValid   (oCodeValid),
    .iCodeReady   (iCodeReady),
    .oChecksumErr (oChecksumErr),
    .oOverrun     (oOverrun),
    .oBusy        (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(negedge iClk);
  endtask

  task automatic check(input string tag, input logic [51:0] obs, input logic [51:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit ean_err(input logic [51:0] c);
    int s = 0;
    bit bad = 1'b0;
    for (int i = 0; i < 13; i++) begin
      int d = int'(c[51-4*i -: 4]);
      if (d > 9) bad = 1'b1;
      s += (i % 2 == 1) ? 3 * d : d;
    end
    return bad || (s % 10 != 0);
  endfunction

  function automatic logic [51:0] put_digit(input logic [51:0] c, input int pos, input logic [3:0] d);
    logic [51:0] r = c;
    r[51-4*pos -: 4] = d;
    return r;
  endfunction

  function automatic bit line_sel(input int l);
    return (l >= 2) && (l <= 8) && ((l - 2) % 3 == 0);
  endfunction

  task automatic sync_pulse();
    iPixelSync = 1'b1;
    step();
    iPixelSync = 1'b0;
  endtask

  task automatic do_line(input int l, input bit framed);
    bit exp_en = framed ? line_sel(l) : 1'b0;
    for (int p = 0; p < 4; p++) begin
      iPixelActive = 1'b1;
      if (p == 0) check($sformatf("scan_en_line%0d_start", l), oScanEnable, exp_en);
      if (p == 3) check($sformatf("scan_en_line%0d_end", l), oScanEnable, exp_en);
      step();
    end
    iPixelActive = 1'b0;
    step();
    step();
  endtask

  task automatic do_read(input logic [51:0] code, input bit report, input int ovr_at);
    bit exp_err = ean_err(code);
    if (report) exp_q.push_back(code);
    iScanNewData = 1'b1;
    iScanCode    = code;
    step();
    iScanNewData = 1'b0;
    check("busy_after_read", oBusy, 1'b1);
    for (int c = 1; c <= 13; c++) begin
      if (c == ovr_at) begin
        iScanNewData = 1'b1;
        iScanCode    = CODE_B;
      end
      step();
      iScanNewData = 1'b0;
      if (c == ovr_at) check("overrun_pulse", oOverrun, 1'b1);
      if (c == ovr_at + 1) check("overrun_quiet", oOverrun, 1'b0);
    end
    check("checksum_err_t14", oChecksumErr, exp_err);
    check("busy_in_compare", oBusy, 1'b1);
    step();
    if (exp_q.size() != 0) begin
      check("code_valid_t15", oCodeValid, 1'b1);
      check("code_value", oCode, exp_q.pop_front());
    end else begin
      check("no_report", oCodeValid, 1'b0);
      check("idle_after_read", oBusy, 1'b0);
      check("checksum_err_pulse_end", oChecksumErr, 1'b0);
    end
  endtask

  task automatic accept(input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      step();
      check("valid_held", oCodeValid, 1'b1);
    end
    iCodeReady = 1'b1;
    step();
    iCodeReady = 1'b0;
    check("valid_drop_after_accept", oCodeValid, 1'b0);
    check("idle_after_accept", oBusy, 1'b0);
  endtask

  initial begin
    step();
    step();
    check("rst_scan_en", oScanEnable, 1'b0);
    check("rst_code", oCode, 52'h0);
    check("rst_code_valid", oCodeValid, 1'b0);
    check("rst_checksum_err", oChecksumErr, 1'b0);
    check("rst_overrun", oOverrun, 1'b0);
    check("rst_busy", oBusy, 1'b0);
    iRstN = 1'b1;
    step();

    do_line(0, 1'b0);
    sync_pulse();
    for (int l = 0; l < 12; l++) do_line(l, 1'b1);

    sync_pulse();
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_A, 1'b1, 0);
    accept(4);

    sync_pulse();
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_A, 1'b0, 0);

    sync_pulse();
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_A, 1'b1, 0);
    accept(0);

    sync_pulse();
    do_read(CODE_B, 1'b0, 0);
    do_read(CODE_B, 1'b0, 0);
    do_read(CODE_A_BAD, 1'b0, 0);
    do_read(put_digit(CODE_A, 1, 4'hA), 1'b0, 0);
    do_read(put_digit(CODE_B, 12, 4'hA), 1'b0, 0);
    do_read(CODE_B, 1'b1, 0);
    accept(1);

    sync_pulse();
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_A, 1'b0, 0);
    sync_pulse();
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_B, 1'b0, 0);
    do_read(CODE_A, 1'b0, 0);

    sync_pulse();
    do_read(CODE_A, 1'b0, 5);
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_A, 1'b1, 0);
    step();
    check("output_held_before_reset", oCodeValid, 1'b1);
    iRstN = 1'b0;
    step();
    check("reset_in_output_valid", oCodeValid, 1'b0);
    check("reset_in_output_busy", oBusy, 1'b0);
    check("reset_in_output_code", oCode, 52'h0);
    check("reset_in_output_scan_en", oScanEnable, 1'b0);
    iRstN = 1'b1;
    step();

    sync_pulse();
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_A, 1'b0, 0);
    do_read(CODE_A, 1'b1, 0);
    accept(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ean13_scan_ctrl.md
# ean13_scan_ctrl

Scan-line scheduler and result confirmer for the EAN-13 scanner in the video pipeline. It chooses which video lines the scanner sees by gating its pixel-active input. It also checks the EAN-13 checksum of every code the scanner reports, and votes across scan lines. A code is passed downstream through a valid/ready handshake only after CONFIRM_COUNT identical valid reads in one frame, and the same code is suppressed from re-reporting for HOLD_FRAMES frames.

## Interface
- H_ACTIVE, 640, active pixels per line (documentation/assertions only)
- V_ACTIVE, 480, active lines per frame
- SCAN_FIRST, 16, first scanned line index (0-based, active lines)
- SCAN_STEP, 8, line spacing between scanned lines, ≥1
- SCAN_LAST, 464, last line that may be scanned, < V_ACTIVE
- CONFIRM_COUNT, 3, identical valid reads needed to report, 1..15
- HOLD_FRAMES, 30, frames the last reported code is suppressed, 0..255
- iClk  in  1  pixel clock, only clock
- iRstN  in  1  reset: synchronous, active-low
- iPixelSync  in  1  one-cycle frame-start pulse, precedes first active pixel
- iPixelActive  in  1  high during active pixels of each line
- iScanNewData  in  1  one-cycle pulse from scanner: iScanCode valid
- iScanCode  in  52  13 BCD digits, digit 0 in [51:48], digit 12 in [3:0]
- oScanEnable  out  1  scanner pixel-active gate, scanner sees iPixelActive & oScanEnable
- oCode  out  52  confirmed code
- oCodeValid  out  1  oCode valid, held until accepted
- iCodeReady  in  1  downstream accepts when oCodeValid & iCodeReady
- oChecksumErr  out  1  one-cycle pulse: a scanner read failed checksum/BCD check
- oOverrun  out  1  one-cycle pulse: scanner read dropped because block busy
- oBusy  out  1  FSM not in IDLE

## Operation
- Line counter: cleared to 0 and frameValid set on iPixelSync; incremented on each iPixelActive 1→0. Before the first iPixelSync after reset, frameValid=0 and oScanEnable=0.
- Selection: a step counter is reloaded at SCAN_FIRST and counts SCAN_STEP; no modulo. Line L is selected iff SCAN_FIRST ≤ L ≤ SCAN_LAST and (L−SCAN_FIRST) is a multiple of SCAN_STEP. oScanEnable is registered and updated only at iPixelSync (for line 0) and at iPixelActive falling edge (for the next line). It is stable for the whole line.
- FSM states:
  - IDLE: iScanNewData latches the code and goes to CHECK.
  - CHECK: 13 cycles, digit i per cycle, accumulating sum += d·(i odd ? 3 : 1). Sum is 8-bit, max 225. Any digit >9 sets a bad flag.
  - COMPARE: 1 cycle. Valid iff !bad and sum mod 10 == 0.
    - Invalid: pulse oChecksumErr and return to IDLE.
    - Valid and equal to candidate: count+1, saturating at 15.
    - Valid and not equal: candidate=code, count=1.
    - If count reaches CONFIRM_COUNT and not (code == lastCode and holdCnt ≠ 0): go to OUTPUT. Otherwise go to IDLE.
  - OUTPUT: oCode=candidate, oCodeValid=1 until iCodeReady. On acceptance: lastCode=oCode, holdCnt=HOLD_FRAMES, count=0, go to IDLE.
- iScanNewData in CHECK, COMPARE or OUTPUT: the read is dropped and oOverrun pulses.
- iPixelSync: clears candidate and count, and decrements holdCnt if nonzero.
  - In CHECK or COMPARE, an in-flight read is compared against the cleared candidate.
  - Does not affect OUTPUT.
- iPixelSync and iScanNewData in the same cycle in IDLE: the clear applies and the read is accepted.

## Timing
- Reset values (iRstN=0 at a clock edge): oScanEnable 0, oCode 0, oCodeValid 0, oChecksumErr 0, oOverrun 0, oBusy 0; FSM IDLE; all counters 0; frameValid 0; lastCode 0.
- Reset mid-operation aborts CHECK/OUTPUT with no handshake completion.
- iScanNewData at cycle t (IDLE): CHECK t+1..t+13, COMPARE t+14, oChecksumErr pulse at t+14 (if invalid), oCodeValid high from t+15.
- oCodeValid falls the cycle after the accepting edge; the earliest new read is accepted in that IDLE cycle.
- oScanEnable changes one cycle after iPixelSync or after the iPixelActive falling edge.
- Horizontal blanking must be ≥1 cycle.

## Structure
- Package ean13_pkg:
  - EAN13_DIGITS=13 and CODE_W=52
  - FSM state enum
  - digit-weight function
- Sub-module ean13_checksum: start/code in, serial 13-cycle accumulate, done/valid out. Used by CHECK.

## Test plan
- Scan-line selection: SCAN_FIRST=2, STEP=3, LAST=8, V_ACTIVE=12 → oScanEnable high on lines 2, 5, 8 only, none before the first iPixelSync.
- Valid code 4006381333931 fed 3 times in one frame, CONFIRM_COUNT=3 → oCodeValid at t+15 of the third read, oCode=0x4006381333931; with iCodeReady held low it stays high, and falls after ready.
- Last digit altered to 2 → oChecksumErr pulse at t+14, no vote. Digit 0xA in any position → oChecksumErr.
- Two valid reads, then iPixelSync, then one read → no output (count=1). Alternating codes A, B, A → no output.
- After a report, same code confirmed again within HOLD_FRAMES=2 frames → suppressed; on the third frame → reported.
- iScanNewData 5 cycles after a previous read → oOverrun pulse, first read unaffected. Reset asserted in OUTPUT → oCodeValid 0 next cycle.
